// File: rtl/neuron_config_loader_if.sv
// Byte-wide valid/ready configuration stream feeding neuron_config_loader.
interface neuron_config_loader_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/neuron_config_loader.sv
// Decodes a config byte stream into shadow registers and commits them atomically to the
// LIF neuron's active weights/shift/threshold. Optional header parity: NEURON_CFG_PARITY_EN.
module neuron_config_loader #(
  parameter int unsigned N_STAGE     = 3,
  parameter int unsigned N_INPUTS    = 2 ** N_STAGE,
  parameter int unsigned N_MEMBRANE  = N_STAGE + 2,
  parameter int unsigned N_THRESHOLD = N_MEMBRANE - 1,
  parameter int unsigned WB          = (N_INPUTS + 7) / 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  neuron_config_loader_if.slave      cfg,
  output logic [N_INPUTS-1:0]        weights_o,
  output logic [2:0]                 shift_o,
  output logic [N_THRESHOLD-1:0]     threshold_o,
  output logic                       membrane_clear_o,
  output logic [3:0]                 cfg_version_o,
`ifdef NEURON_CFG_PARITY_EN
  output logic                       busy_o,
  output logic                       cfg_error_o
`else
  output logic                       busy_o
`endif
);

  localparam int unsigned CntW = (WB > 1) ? $clog2(WB) : 1;

  typedef enum logic [2:0] {StIdle, StWeights, StShift, StThresh, StCommit} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [N_INPUTS-1:0]    shadow_w_q, shadow_w_d, weights_q, weights_d;
  logic [2:0]             shadow_shift_q, shadow_shift_d, shift_q, shift_d;
  logic [N_THRESHOLD-1:0] shadow_thr_q, shadow_thr_d, thr_q, thr_d;
  logic [3:0]             version_q, version_d;
  logic                   clear_q, clear_d;
  logic                   xfer, hdr_ok;
  logic [1:0]             opcode;

`ifdef NEURON_CFG_PARITY_EN
  logic err_q, err_d;
  assign hdr_ok      = ~^cfg.data;
  assign cfg_error_o = err_q;
`else
  assign hdr_ok = 1'b1;
`endif

  assign cfg.ready = (state_q != StCommit);
  assign xfer      = cfg.valid && cfg.ready;
  assign opcode    = cfg.data[7:6];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shadow_w_d     = shadow_w_q;
    shadow_shift_d = shadow_shift_q;
    shadow_thr_d   = shadow_thr_q;
    weights_d      = weights_q;
    shift_d        = shift_q;
    thr_d          = thr_q;
    version_d      = version_q;
    clear_d        = 1'b0;
`ifdef NEURON_CFG_PARITY_EN
    err_d          = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (!hdr_ok) begin
`ifdef NEURON_CFG_PARITY_EN
            err_d = 1'b1;
`endif
          end else begin
            unique case (opcode)
              2'b00: begin
                state_d = StWeights;
                cnt_d   = '0;
              end
              2'b01: state_d = StShift;
              2'b10: clear_d = 1'b1;
              default: begin
                state_d = StCommit;
`ifdef NEURON_CFG_PARITY_EN
                err_d   = 1'b0;
`endif
              end
            endcase
          end
        end
      end
      StWeights: begin
        if (xfer) begin
          // Byte k lands on weight bits 8k..8k+7; bits past N_INPUTS never exist.
          for (int i = 0; i < int'(N_INPUTS); i++) begin
            if ((i / 8) == int'(cnt_q)) shadow_w_d[i] = cfg.data[i % 8];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(WB - 1)) state_d = StIdle;
        end
      end
      StShift: begin
        if (xfer) begin
          shadow_shift_d = cfg.data[2:0];
          state_d        = StThresh;
        end
      end
      StThresh: begin
        if (xfer) begin
          shadow_thr_d = cfg.data[N_THRESHOLD-1:0];
          state_d      = StIdle;
        end
      end
      StCommit: begin
        weights_d = shadow_w_q;
        shift_d   = shadow_shift_q;
        thr_d     = shadow_thr_q;
        version_d = version_q + 4'd1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      shadow_w_q     <= '0;
      shadow_shift_q <= '0;
      shadow_thr_q   <= '1;
      weights_q      <= '0;
      shift_q        <= '0;
      thr_q          <= '1;
      version_q      <= '0;
      clear_q        <= 1'b0;
`ifdef NEURON_CFG_PARITY_EN
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_w_q     <= shadow_w_d;
      shadow_shift_q <= shadow_shift_d;
      shadow_thr_q   <= shadow_thr_d;
      weights_q      <= weights_d;
      shift_q        <= shift_d;
      thr_q          <= thr_d;
      version_q      <= version_d;
      clear_q        <= clear_d;
`ifdef NEURON_CFG_PARITY_EN
      err_q          <= err_d;
`endif
    end
  end

  assign weights_o        = weights_q;
  assign shift_o          = shift_q;
  assign threshold_o      = thr_q;
  assign membrane_clear_o = clear_q;
  assign cfg_version_o    = version_q;
  assign busy_o           = (state_q != StIdle);

endmodule
